// File: rtl/chunked_adder_seq.sv
// -----------------------------------------------------------------------------
// chunked_adder_seq
//
// Multi-cycle wide adder. It accepts one wide operand pair through a
// valid/ready handshake and adds it one DATA_WIDTH-bit chunk per clock. The
// least significant chunk is added first, and a registered carry links each
// chunk to the next. After the last chunk the full-width sum and the final
// carry are offered downstream through a second valid/ready handshake.
//
// Parameters
//   DATA_WIDTH : width of one adder chunk in bits
//   NUM_CHUNKS : number of chunks (>= 1); operand width W = DATA_WIDTH*NUM_CHUNKS
//
// Ports
//   CLK        in   1  clock, all state changes on the rising edge
//   RST        in   1  synchronous active-high reset
//   In_valid   in   1  upstream presents an operand pair
//   In_ready   out  1  block can accept an operand pair (IDLE only)
//   A, B       in   W  operands
//   Carry_in   in   1  carry into chunk 0
//   Out_valid  out  1  Sum/Carry_out are valid (DONE only)
//   Out_ready  in   1  downstream accepts the result
//   Sum        out  W  registered wide sum
//   Carry_out  out  1  carry out of the most significant chunk
//   Busy       out  1  high while an operation is in RUN or DONE
// -----------------------------------------------------------------------------
module chunked_adder_seq #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             In_valid,
    output logic                             In_ready,
    input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] A,
    input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] B,
    input  logic                             Carry_in,
    output logic                             Out_valid,
    input  logic                             Out_ready,
    output logic [DATA_WIDTH*NUM_CHUNKS-1:0] Sum,
    output logic                             Carry_out,
    output logic                             Busy
);

    localparam int W     = DATA_WIDTH * NUM_CHUNKS;
    // A single-chunk build still needs a 1-bit index, so the width never drops to zero.
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Returns chunk number idx of a wide vector. The loop uses constant
    // part-selects so that no variable-width shifter is built.
    function automatic logic [DATA_WIDTH-1:0] get_chunk(
        input logic [W-1:0]     vec,
        input logic [IDX_W-1:0] idx
    );
        logic [DATA_WIDTH-1:0] res;
        res = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (idx == IDX_W'(k)) begin
                res = vec[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Returns vec with chunk number idx replaced by val.
    function automatic logic [W-1:0] put_chunk(
        input logic [W-1:0]            vec,
        input logic [IDX_W-1:0]        idx,
        input logic [DATA_WIDTH-1:0]   val
    );
        logic [W-1:0] res;
        res = vec;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (idx == IDX_W'(k)) begin
                res[k*DATA_WIDTH +: DATA_WIDTH] = val;
            end else begin
                res[k*DATA_WIDTH +: DATA_WIDTH] = vec[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return res;
    endfunction

    // One adder slice: {carry, sum} = a + b + cin, evaluated at DATA_WIDTH+1 bits.
    function automatic logic [DATA_WIDTH:0] chunk_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic                  cin
    );
        return {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t             state_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [W-1:0]       sum_r;
    logic               carry_out_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic [DATA_WIDTH:0] chunk_res_s;
    logic [W-1:0]        sum_next_s;

    // Adds the chunk selected by idx_r and merges the result into the sum.
    always_comb begin
        chunk_res_s = chunk_add(get_chunk(a_r, idx_r), get_chunk(b_r, idx_r), carry_r);
        sum_next_s  = put_chunk(sum_r, idx_r, chunk_res_s[DATA_WIDTH-1:0]);
    end

    // Control FSM and datapath. The handshake flags are registered alongside
    // each state change, so they depend only on state and never
    // combinationally on In_valid or Out_ready.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            carry_r     <= 1'b0;
            idx_r       <= IDX_ZERO;
            sum_r       <= {W{1'b0}};
            carry_out_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (In_valid && in_ready_r) begin
                        a_r        <= A;
                        b_r        <= B;
                        carry_r    <= Carry_in;
                        sum_r      <= {W{1'b0}};
                        idx_r      <= IDX_ZERO;
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    sum_r   <= sum_next_s;
                    carry_r <= chunk_res_s[DATA_WIDTH];
                    if (idx_r == LAST_IDX) begin
                        carry_out_r <= chunk_res_s[DATA_WIDTH];
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        idx_r       <= idx_r + IDX_ONE;
                    end
                end

                ST_DONE: begin
                    // Sum and Carry_out are left untouched on the way out, so
                    // they keep their values after the result is taken.
                    if (Out_ready && out_valid_r) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end

                default: begin
                    // Unreachable encoding: return to a clean idle condition.
                    state_r     <= ST_IDLE;
                    idx_r       <= IDX_ZERO;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign In_ready  = in_ready_r;
    assign Out_valid = out_valid_r;
    assign Busy      = busy_r;
    assign Sum       = sum_r;
    assign Carry_out = carry_out_r;

endmodule

// File: tb/tb_chunked_adder_seq.sv
module tb_chunked_adder_seq;

    logic        CLK;
    logic        RST;
    logic        In_valid;
    logic        In_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Carry_in;
    logic        Out_valid;
    logic        Out_ready;
    logic [15:0] Sum;
    logic        Carry_out;
    logic        Busy;

    logic        in_valid_1;
    logic        in_ready_1;
    logic [3:0]  a_1;
    logic [3:0]  b_1;
    logic        carry_in_1;
    logic        out_valid_1;
    logic        out_ready_1;
    logic [3:0]  sum_1;
    logic        carry_out_1;
    logic        busy_1;

    int n_compared;
    int n_mismatched;

    chunked_adder_seq #(.DATA_WIDTH(4), .NUM_CHUNKS(4)) u_dut (
        .CLK(CLK), .RST(RST),
        .In_valid(In_valid), .In_ready(In_ready),
        .A(A), .B(B), .Carry_in(Carry_in),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Sum(Sum), .Carry_out(Carry_out), .Busy(Busy)
    );

    chunked_adder_seq #(.DATA_WIDTH(4), .NUM_CHUNKS(1)) u_dut1 (
        .CLK(CLK), .RST(RST),
        .In_valid(in_valid_1), .In_ready(in_ready_1),
        .A(a_1), .B(b_1), .Carry_in(carry_in_1),
        .Out_valid(out_valid_1), .Out_ready(out_ready_1),
        .Sum(sum_1), .Carry_out(carry_out_1), .Busy(busy_1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present one operand pair for exactly one edge; called just after an edge with In_ready=1.
    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin);
        A = a; B = b; Carry_in = cin; In_valid = 1'b1;
        @(posedge CLK); #1;
        In_valid = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        n_compared += 5;
        if (In_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_in_ready got %b want 1", In_ready); end
        if (Out_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_out_valid got %b want 0", Out_valid); end
        if (Busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy got %b want 0", Busy); end
        if (Sum !== 16'h0000) begin n_mismatched++; $display("FAIL reset_sum got %h want 0000", Sum); end
        if (Carry_out !== 1'b0) begin n_mismatched++; $display("FAIL reset_cout got %b want 0", Carry_out); end
    endtask

    task automatic test_basic;
        int cnt;
        Out_ready = 1'b1;
        n_compared++;
        if (In_ready !== 1'b1) begin n_mismatched++; $display("FAIL basic_ready got %b want 1", In_ready); end
        accept(16'h0006, 16'h0001, 1'b1);
        cnt = 0;
        while (Out_valid !== 1'b1 && cnt < 20) begin @(posedge CLK); #1; cnt++; end
        n_compared += 4;
        if (cnt !== 4) begin n_mismatched++; $display("FAIL basic_latency got %0d want 4", cnt); end
        if (Sum !== 16'h0008) begin n_mismatched++; $display("FAIL basic_sum got %h want 0008", Sum); end
        if (Carry_out !== 1'b0) begin n_mismatched++; $display("FAIL basic_cout got %b want 0", Carry_out); end
        if (Busy !== 1'b1) begin n_mismatched++; $display("FAIL basic_busy got %b want 1", Busy); end
        @(posedge CLK); #1;
        n_compared += 2;
        if (Out_valid !== 1'b0) begin n_mismatched++; $display("FAIL basic_valid_1cyc got %b want 0", Out_valid); end
        if (In_ready !== 1'b1) begin n_mismatched++; $display("FAIL basic_back_idle got %b want 1", In_ready); end
    endtask

    task automatic test_carry_chain;
        int cnt;
        accept(16'hFFFF, 16'h0001, 1'b0);
        cnt = 0;
        while (Out_valid !== 1'b1 && cnt < 20) begin @(posedge CLK); #1; cnt++; end
        n_compared += 3;
        if (cnt !== 4) begin n_mismatched++; $display("FAIL chain_latency got %0d want 4", cnt); end
        if (Sum !== 16'h0000) begin n_mismatched++; $display("FAIL chain_sum got %h want 0000", Sum); end
        if (Carry_out !== 1'b1) begin n_mismatched++; $display("FAIL chain_cout got %b want 1", Carry_out); end
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure;
        int cnt;
        Out_ready = 1'b0;
        accept(16'h0008, 16'h0002, 1'b0);
        cnt = 0;
        while (Out_valid !== 1'b1 && cnt < 20) begin @(posedge CLK); #1; cnt++; end
        n_compared++;
        if (cnt !== 4) begin n_mismatched++; $display("FAIL bp_latency got %0d want 4", cnt); end
        // A competing request while the result is stalled must be ignored.
        A = 16'h1234; B = 16'h0000; Carry_in = 1'b0; In_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            n_compared += 3;
            if (Out_valid !== 1'b1) begin n_mismatched++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", i, Out_valid); end
            if (Sum !== 16'h000A) begin n_mismatched++; $display("FAIL bp_hold_sum cyc %0d got %h want 000a", i, Sum); end
            if (In_ready !== 1'b0) begin n_mismatched++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, In_ready); end
        end
        Out_ready = 1'b1;
        @(posedge CLK); #1;
        n_compared += 3;
        if (Out_valid !== 1'b0) begin n_mismatched++; $display("FAIL bp_release_valid got %b want 0", Out_valid); end
        if (In_ready !== 1'b1) begin n_mismatched++; $display("FAIL bp_release_ready got %b want 1", In_ready); end
        if (Sum !== 16'h000A) begin n_mismatched++; $display("FAIL bp_sum_kept got %h want 000a", Sum); end
        // In_valid is still high: the pending request is taken at the next edge.
        @(posedge CLK); #1;
        In_valid = 1'b0;
        n_compared++;
        if (Busy !== 1'b1) begin n_mismatched++; $display("FAIL bp_second_accept got %b want 1", Busy); end
        cnt = 0;
        while (Out_valid !== 1'b1 && cnt < 20) begin @(posedge CLK); #1; cnt++; end
        n_compared += 2;
        if (cnt !== 4) begin n_mismatched++; $display("FAIL bp2_latency got %0d want 4", cnt); end
        if (Sum !== 16'h1234) begin n_mismatched++; $display("FAIL bp2_sum got %h want 1234", Sum); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid;
        int seen;
        n_compared++;
        if (In_ready !== 1'b1) begin n_mismatched++; $display("FAIL rmid_ready got %b want 1", In_ready); end
        accept(16'h8888, 16'h8888, 1'b0);
        @(posedge CLK); #1;           // first RUN edge done
        RST = 1'b1;                   // second RUN edge sees reset
        @(posedge CLK); #1;
        RST = 1'b0;
        n_compared += 5;
        if (In_ready !== 1'b1) begin n_mismatched++; $display("FAIL rmid_in_ready got %b want 1", In_ready); end
        if (Out_valid !== 1'b0) begin n_mismatched++; $display("FAIL rmid_out_valid got %b want 0", Out_valid); end
        if (Busy !== 1'b0) begin n_mismatched++; $display("FAIL rmid_busy got %b want 0", Busy); end
        if (Sum !== 16'h0000) begin n_mismatched++; $display("FAIL rmid_sum got %h want 0000", Sum); end
        if (Carry_out !== 1'b0) begin n_mismatched++; $display("FAIL rmid_cout got %b want 0", Carry_out); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (Out_valid === 1'b1) seen++;
        end
        n_compared++;
        if (seen !== 0) begin n_mismatched++; $display("FAIL rmid_no_result got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_single_chunk;
        int cnt;
        out_ready_1 = 1'b1;
        n_compared++;
        if (in_ready_1 !== 1'b1) begin n_mismatched++; $display("FAIL nc1_ready got %b want 1", in_ready_1); end
        a_1 = 4'b1000; b_1 = 4'b1000; carry_in_1 = 1'b1; in_valid_1 = 1'b1;
        @(posedge CLK); #1;
        in_valid_1 = 1'b0;
        cnt = 0;
        while (out_valid_1 !== 1'b1 && cnt < 20) begin @(posedge CLK); #1; cnt++; end
        n_compared += 3;
        if (cnt !== 1) begin n_mismatched++; $display("FAIL nc1_latency got %0d want 1", cnt); end
        if (sum_1 !== 4'b0001) begin n_mismatched++; $display("FAIL nc1_sum got %b want 0001", sum_1); end
        if (carry_out_1 !== 1'b1) begin n_mismatched++; $display("FAIL nc1_cout got %b want 1", carry_out_1); end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back;
        logic [15:0] pa [3];
        logic [15:0] pb [3];
        logic        pc [3];
        logic [15:0] es [3];
        logic        ec [3];
        int acc, got, cyc, last_t;
        logic prev_rdy;
        pa[0] = 16'h1234; pb[0] = 16'h4321; pc[0] = 1'b0; es[0] = 16'h5555; ec[0] = 1'b0;
        pa[1] = 16'hABCD; pb[1] = 16'h5432; pc[1] = 1'b1; es[1] = 16'h0000; ec[1] = 1'b1;
        pa[2] = 16'h9F3C; pb[2] = 16'h80E5; pc[2] = 1'b1; es[2] = 16'h2022; ec[2] = 1'b1;
        Out_ready = 1'b1;
        A = pa[0]; B = pb[0]; Carry_in = pc[0]; In_valid = 1'b1;
        acc = 0; got = 0; cyc = 0; last_t = 0;
        prev_rdy = In_ready;
        while (got < 3 && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
            if (prev_rdy === 1'b1 && In_ready === 1'b0) begin
                acc++;
                if (acc < 3) begin
                    A = pa[acc]; B = pb[acc]; Carry_in = pc[acc];
                end else begin
                    In_valid = 1'b0;
                end
            end
            if (Out_valid === 1'b1) begin
                n_compared += 2;
                if (Sum !== es[got]) begin n_mismatched++; $display("FAIL b2b_sum[%0d] got %h want %h", got, Sum, es[got]); end
                if (Carry_out !== ec[got]) begin n_mismatched++; $display("FAIL b2b_cout[%0d] got %b want %b", got, Carry_out, ec[got]); end
                if (got > 0) begin
                    n_compared++;
                    if (cyc - last_t !== 6) begin n_mismatched++; $display("FAIL b2b_spacing[%0d] got %0d want 6", got, cyc - last_t); end
                end
                last_t = cyc;
                got++;
            end
            prev_rdy = In_ready;
        end
        In_valid = 1'b0;
        n_compared++;
        if (got !== 3) begin n_mismatched++; $display("FAIL b2b_count got %0d want 3", got); end
        @(posedge CLK); #1;
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        RST = 1'b1; In_valid = 1'b0; A = 16'h0000; B = 16'h0000; Carry_in = 1'b0; Out_ready = 1'b0;
        in_valid_1 = 1'b0; a_1 = 4'h0; b_1 = 4'h0; carry_in_1 = 1'b0; out_ready_1 = 1'b0;
        test_reset;
        test_basic;
        test_carry_chain;
        test_backpressure;
        test_reset_mid;
        test_single_chunk;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
